// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table engine: sweep FSM states,
// default table dimensions and the config-select width helper.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int DEF_N_IN  = 4;
    localparam int DEF_N_OUT = 10;

    // A single function still needs a one-bit select port.
    function automatic int sel_width(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl.sv
// Sweep sequencer: walks every truth-table row through a valid/ready
// handshake, then pulses sweep_done for one cycle.
module tt_sweep_ctrl
    import tt_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sweep_start,
    input  logic            row_ready,
    output logic            row_valid,
    output logic [N_IN-1:0] row_idx,
    output logic [N_IN-1:0] row_nxt,
    output logic            run_nxt,
    output logic            sweep_busy,
    output logic            sweep_done
);

    // One spare counter bit so the increment past the last row never wraps.
    localparam logic [N_IN:0] LAST_ROW = (N_IN+1)'((1 << N_IN) - 1);

    sweep_state_t  state, state_nxt;
    logic [N_IN:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (row_ready) begin
                    cnt_nxt = cnt + (N_IN+1)'(1);
                    if (cnt == LAST_ROW) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign row_valid  = (state == RUN);
    assign sweep_busy = (state != IDLE);
    assign sweep_done = (state == DONE);
    assign row_idx    = cnt[N_IN-1:0];
    // Lets the parent register row_out in step with the counter.
    assign row_nxt    = cnt_nxt[N_IN-1:0];
    assign run_nxt    = (state_nxt == RUN);

endmodule

// File: rtl/truth_table_engine.sv
// Configurable bank of N_OUT boolean functions of N_IN inputs, with a live
// registered evaluation port and a handshaked full-table sweep.
module truth_table_engine
    import tt_pkg::*;
#(
    parameter  int N_IN  = DEF_N_IN,
    parameter  int N_OUT = DEF_N_OUT,
    localparam int SEL_W = sel_width(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in_vec,
    output logic [N_OUT-1:0] out_vec,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [N_IN-1:0]  cfg_row,
    input  logic             cfg_bit,
    input  logic             sweep_start,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [N_IN-1:0]  row_idx,
    output logic [N_OUT-1:0] row_out,
    output logic             sweep_busy,
    output logic             sweep_done
);

    localparam int ROWS = 1 << N_IN;

    logic [ROWS-1:0]  lut     [N_OUT];
    logic [ROWS-1:0]  lut_nxt [N_OUT];
    logic [N_OUT-1:0] rd_live;
    logic [N_OUT-1:0] rd_row;
    logic [N_IN-1:0]  row_nxt;
    logic             run_nxt;

    tt_sweep_ctrl #(
        .N_IN(N_IN)
    ) u_sweep_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .sweep_start(sweep_start),
        .row_ready  (row_ready),
        .row_valid  (row_valid),
        .row_idx    (row_idx),
        .row_nxt    (row_nxt),
        .run_nxt    (run_nxt),
        .sweep_busy (sweep_busy),
        .sweep_done (sweep_done)
    );

    // Out-of-range selects match no function, so they drop out naturally.
    always_comb begin
        lut_nxt = lut;
        if (cfg_we && !sweep_busy) begin
            for (int f = 0; f < N_OUT; f++) begin
                if (SEL_W'(f) == cfg_sel) begin
                    lut_nxt[f][cfg_row] = cfg_bit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int f = 0; f < N_OUT; f++) begin
                lut[f] <= '0;
            end
        end else begin
            lut <= lut_nxt;
        end
    end

    // Live evaluation sees the pre-write table; the sweep column follows the
    // post-edge table so a write made alongside sweep_start is not stale.
    always_comb begin
        rd_live = '0;
        rd_row  = '0;
        for (int f = 0; f < N_OUT; f++) begin
            rd_live[f] = lut[f][in_vec];
            rd_row[f]  = lut_nxt[f][row_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vec <= '0;
            row_out <= '0;
        end else begin
            out_vec <= rd_live;
            row_out <= run_nxt ? rd_row : '0;
        end
    end

endmodule

// File: tb/tb_truth_table_engine.sv
// Directed bench for truth_table_engine: programs f2/f3 from hand-built
// truth tables and checks evaluation, sweep handshake, locking and reset.
module tb_truth_table_engine;

    localparam int N_IN  = 4;
    localparam int N_OUT = 10;

    // f3 = y&x | z&w  -> rows 6,7,9,11,13,14,15
    localparam logic [15:0] F3_TT = 16'hEAC0;
    // f2 = at least three of four inputs -> rows 7,11,13,14,15
    localparam logic [15:0] F2_TT = 16'hE880;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_IN-1:0]  in_vec;
    logic [N_OUT-1:0] out_vec;
    logic             cfg_we;
    logic [3:0]       cfg_sel;
    logic [N_IN-1:0]  cfg_row;
    logic             cfg_bit;
    logic             sweep_start;
    logic             row_valid;
    logic             row_ready;
    logic [N_IN-1:0]  row_idx;
    logic [N_OUT-1:0] row_out;
    logic             sweep_busy;
    logic             sweep_done;

    int checks = 0;
    int errors = 0;

    truth_table_engine #(
        .N_IN (N_IN),
        .N_OUT(N_OUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vec     (in_vec),
        .out_vec    (out_vec),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_row    (cfg_row),
        .cfg_bit    (cfg_bit),
        .sweep_start(sweep_start),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_idx    (row_idx),
        .row_out    (row_out),
        .sweep_busy (sweep_busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    function automatic logic [N_OUT-1:0] exp_row(input int r);
        logic [N_OUT-1:0] e;
        e    = '0;
        e[3] = F3_TT[r];
        e[2] = F2_TT[r];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bit(input int f, input int r, input logic b);
        cfg_we  = 1'b1;
        cfg_sel = 4'(f);
        cfg_row = 4'(r);
        cfg_bit = b;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic program_fn(input int f, input logic [15:0] tt);
        for (int r = 0; r < 16; r++) begin
            write_bit(f, r, tt[r]);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_vec      = 4'hF;
        cfg_we      = 1'b1;
        cfg_sel     = 4'd3;
        cfg_row     = 4'hF;
        cfg_bit     = 1'b1;
        sweep_start = 1'b1;
        tick();
        tick();
        checks++;
        if (out_vec !== '0 || row_out !== '0 || row_idx !== '0 || row_valid !== 1'b0
            || sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got out=%h row=%h idx=%h v=%b b=%b d=%b required all 0",
                     out_vec, row_out, row_idx, row_valid, sweep_busy, sweep_done);
        end
        cfg_we      = 1'b0;
        sweep_start = 1'b0;
        rst_n       = 1'b1;
        tick();
        checks++;
        if (out_vec !== '0 || sweep_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got out=%h busy=%b required 0/0", out_vec, sweep_busy);
        end
    endtask

    task automatic test_eval();
        int vecs [6] = '{7, 9, 2, 15, 0, 6};
        program_fn(3, F3_TT);
        program_fn(2, F2_TT);
        foreach (vecs[i]) begin
            in_vec = 4'(vecs[i]);
            tick();
            checks++;
            if (out_vec !== exp_row(vecs[i])) begin
                errors++;
                $display("[TB] FAIL eval_in%0d: got %h required %h", vecs[i], out_vec, exp_row(vecs[i]));
            end
        end
    endtask

    task automatic test_write_timing();
        in_vec = 4'd5;
        tick();
        write_bit(0, 5, 1'b1);
        checks++;
        if (out_vec !== exp_row(5)) begin
            errors++;
            $display("[TB] FAIL write_same_cycle: got %h required %h", out_vec, exp_row(5));
        end
        tick();
        checks++;
        if (out_vec !== (exp_row(5) | 10'h001)) begin
            errors++;
            $display("[TB] FAIL write_visible: got %h required %h", out_vec, exp_row(5) | 10'h001);
        end
        write_bit(0, 5, 1'b0);
        tick();
        checks++;
        if (out_vec !== exp_row(5)) begin
            errors++;
            $display("[TB] FAIL write_restore: got %h required %h", out_vec, exp_row(5));
        end
        write_bit(10, 2, 1'b1);
        write_bit(15, 2, 1'b1);
        in_vec = 4'd2;
        tick();
        checks++;
        if (out_vec !== exp_row(2)) begin
            errors++;
            $display("[TB] FAIL sel_out_of_range: got %h required %h", out_vec, exp_row(2));
        end
    endtask

    task automatic test_sweep_full();
        int exp_idx   = 0;
        int run_cyc   = 0;
        int done_cyc  = 0;
        int done_cnt  = 0;
        row_ready   = 1'b1;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            if (row_valid) begin
                run_cyc++;
                checks++;
                if (exp_idx > 15) begin
                    errors++;
                    $display("[TB] FAIL full_extra_row: got idx %0d required no row", row_idx);
                end else if (row_idx !== 4'(exp_idx) || row_out !== exp_row(exp_idx)) begin
                    errors++;
                    $display("[TB] FAIL full_row%0d: got idx %0d out %h required idx %0d out %h",
                             exp_idx, row_idx, row_out, exp_idx, exp_row(exp_idx));
                end
                exp_idx++;
            end
            if (sweep_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = t;
            end
            tick();
        end
        checks++;
        if (run_cyc != 16 || done_cyc != 17 || done_cnt != 1 || sweep_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_timing: got run=%0d done_at=%0d done_cnt=%0d busy=%b required 16/17/1/0",
                     run_cyc, done_cyc, done_cnt, sweep_busy);
        end
    endtask

    task automatic test_ready_toggle();
        int exp_idx  = 0;
        int run_cyc  = 0;
        int done_cnt = 0;
        row_ready   = 1'b0;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int t = 1; t <= 50; t++) begin
            if (row_valid) begin
                run_cyc++;
                checks++;
                if (exp_idx > 15) begin
                    errors++;
                    $display("[TB] FAIL toggle_extra_row: got idx %0d required no row", row_idx);
                end else if (row_idx !== 4'(exp_idx) || row_out !== exp_row(exp_idx)) begin
                    errors++;
                    $display("[TB] FAIL toggle_t%0d: got idx %0d out %h required idx %0d out %h",
                             t, row_idx, row_out, exp_idx, exp_row(exp_idx));
                end
            end
            if (sweep_done) done_cnt++;
            row_ready = (t % 2 == 0);
            if (row_valid && row_ready) exp_idx++;
            tick();
        end
        row_ready = 1'b1;
        checks++;
        if (exp_idx != 16 || run_cyc != 32 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL toggle_totals: got xfers=%0d run=%0d done=%0d required 16/32/1",
                     exp_idx, run_cyc, done_cnt);
        end
    endtask

    task automatic test_lock();
        bit seen_done = 0;
        row_ready   = 1'b1;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick();
        tick();
        tick();
        row_ready   = 1'b0;
        cfg_we      = 1'b1;
        cfg_sel     = 4'd0;
        cfg_row     = 4'd3;
        cfg_bit     = 1'b1;
        sweep_start = 1'b1;
        tick();
        cfg_we      = 1'b0;
        sweep_start = 1'b0;
        checks++;
        if (row_idx !== 4'd3 || row_out !== exp_row(3) || sweep_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_hold: got idx %0d out %h busy %b required idx 3 out %h busy 1",
                     row_idx, row_out, sweep_busy, exp_row(3));
        end
        row_ready = 1'b1;
        for (int t = 0; t < 30 && !seen_done; t++) begin
            tick();
            if (sweep_done) seen_done = 1;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("[TB] FAIL lock_done_timeout: got no sweep_done required pulse within 30 cycles");
        end
        in_vec = 4'd3;
        tick();
        tick();
        checks++;
        if (out_vec !== exp_row(3)) begin
            errors++;
            $display("[TB] FAIL lock_lut_unchanged: got %h required %h", out_vec, exp_row(3));
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        in_vec      = 4'd15;
        row_ready   = 1'b1;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int t = 0; t < 20 && row_idx != 4'd5; t++) tick();
        checks++;
        if (row_idx !== 4'd5 || out_vec !== exp_row(15)) begin
            errors++;
            $display("[TB] FAIL mid_reach_row5: got idx %0d out %h required idx 5 out %h",
                     row_idx, out_vec, exp_row(15));
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_vec !== '0 || row_out !== '0 || row_idx !== '0 || row_valid !== 1'b0
            || sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got out=%h row=%h idx=%h v=%b b=%b d=%b required all 0",
                     out_vec, row_out, row_idx, row_valid, sweep_busy, sweep_done);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (sweep_done || sweep_busy || row_valid) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL mid_no_done: got %0d active cycles required 0", bad);
        end
        checks++;
        if (out_vec !== '0) begin
            errors++;
            $display("[TB] FAIL mid_lut_cleared: got %h required 0", out_vec);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_vec      = '0;
        cfg_we      = 1'b0;
        cfg_sel     = '0;
        cfg_row     = '0;
        cfg_bit     = 1'b0;
        sweep_start = 1'b0;
        row_ready   = 1'b0;
        test_reset();
        test_eval();
        test_write_timing();
        test_sweep_full();
        test_ready_toggle();
        test_lock();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
